// File: rtl/common.sv
// Shared types and widths for the memory port arbiter slice.
// Contents: bus widths, store funct3 encoding, arbiter state/owner enums and
// the memory request holding-register layout.
package common;

   localparam int unsigned MEM_ADDRESS_WIDTH = 32;
   localparam int unsigned REGISTER_WIDTH    = 32;

   // Store funct3 encoding, also used as the data request access size.
   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } STypeFunct3;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RSP
   } arb_state_t;

   typedef enum logic {
      OWNER_FETCH,
      OWNER_DATA
   } arb_owner_t;

   typedef struct packed {
      logic [MEM_ADDRESS_WIDTH-1:0] addr;
      logic                         write;
      logic [3:0]                   wstrb;
      logic [REGISTER_WIDTH-1:0]    wdata;
   } mem_req_t;

endpackage

// File: rtl/store_formatter.sv
// Combinational store formatter: derives byte strobes and lane-replicated
// write data from the store size and the low address bits.
// Ports:
//   size       - store funct3 (SB/SH/SW); other values are illegal
//   addr_lo    - address bits [1:0], select the byte lanes
//   wdata      - raw store data from the register file
//   wstrb      - byte strobes for the memory bus
//   wdata_fmt  - store data replicated across the lanes
//   misaligned - store cannot be issued (misaligned or illegal size)
module store_formatter
   import common::*;
(
   input  logic [2:0]                size,
   input  logic [1:0]                addr_lo,
   input  logic [REGISTER_WIDTH-1:0] wdata,
   output logic [3:0]                wstrb,
   output logic [REGISTER_WIDTH-1:0] wdata_fmt,
   output logic                      misaligned
);

   always_comb begin
      wstrb      = 4'b0000;
      wdata_fmt  = '0;
      misaligned = 1'b0;
      case (size)
         SB: begin
            wstrb     = 4'b0001 << addr_lo;
            wdata_fmt = {4{wdata[7:0]}};
         end
         SH: begin
            wstrb      = 4'b0011 << addr_lo;
            wdata_fmt  = {2{wdata[15:0]}};
            misaligned = addr_lo[0];
         end
         SW: begin
            wstrb      = 4'b1111;
            wdata_fmt  = wdata;
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch and
// the data memory stage. One transaction in flight; data has priority, with a
// starvation counter forcing a fetch grant after STARVE_LIMIT data grants.
// Ports:
//   clk, rst_n                              - clock, async active-low reset
//   if_req_valid/ready/addr, if_flush       - fetch request and redirect flush
//   if_rsp_valid/data                       - instruction response
//   dm_req_valid/ready/addr/write/size/wdata - data request
//   dm_rsp_valid/rdata, dm_rsp_error        - load response, store rejection
//   mem_req_valid/ready/addr/write/wstrb/wdata - memory bus request
//   mem_rsp_valid/rdata                     - memory bus read response
module memory_port_arbiter
   import common::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,

   input  logic                         if_req_valid,
   output logic                         if_req_ready,
   input  logic [MEM_ADDRESS_WIDTH-1:0] if_req_addr,
   input  logic                         if_flush,
   output logic                         if_rsp_valid,
   output logic [REGISTER_WIDTH-1:0]    if_rsp_data,

   input  logic                         dm_req_valid,
   output logic                         dm_req_ready,
   input  logic [MEM_ADDRESS_WIDTH-1:0] dm_req_addr,
   input  logic                         dm_req_write,
   input  logic [2:0]                   dm_req_size,
   input  logic [REGISTER_WIDTH-1:0]    dm_req_wdata,
   output logic                         dm_rsp_valid,
   output logic [REGISTER_WIDTH-1:0]    dm_rsp_rdata,
   output logic                         dm_rsp_error,

   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic [MEM_ADDRESS_WIDTH-1:0] mem_req_addr,
   output logic                         mem_req_write,
   output logic [3:0]                   mem_req_wstrb,
   output logic [REGISTER_WIDTH-1:0]    mem_req_wdata,
   input  logic                         mem_rsp_valid,
   input  logic [REGISTER_WIDTH-1:0]    mem_rsp_rdata
);

   localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   arb_state_t      state;
   arb_owner_t      owner;
   mem_req_t        hold;
   logic [CntW-1:0] starve_cnt;
   logic            drop;

   logic                      grant_fetch;
   logic                      grant_data;
   logic                      if_hs;
   logic                      dm_hs;
   logic [3:0]                fmt_wstrb;
   logic [REGISTER_WIDTH-1:0] fmt_wdata;
   logic                      fmt_misaligned;
   logic                      flush_hit;

   // Fetch addresses are word aligned on the bus; low bits are dropped.
   logic unused_if_addr_lo;
   assign unused_if_addr_lo = ^if_req_addr[1:0];

   store_formatter u_store_formatter (
      .size       (dm_req_size),
      .addr_lo    (dm_req_addr[1:0]),
      .wdata      (dm_req_wdata),
      .wstrb      (fmt_wstrb),
      .wdata_fmt  (fmt_wdata),
      .misaligned (fmt_misaligned)
   );

   // Fetch wins only when alone or when it has waited out the starvation limit.
   assign grant_fetch = if_req_valid && (!dm_req_valid || (starve_cnt == CntMax));
   assign grant_data  = dm_req_valid && !grant_fetch;

   assign if_req_ready = (state == IDLE) && grant_fetch;
   assign dm_req_ready = (state == IDLE) && grant_data;
   assign if_hs        = if_req_ready;
   assign dm_hs        = dm_req_ready;

   assign flush_hit = if_flush && (owner == OWNER_FETCH);

   assign mem_req_valid = (state == ISSUE);
   assign mem_req_addr  = hold.addr;
   assign mem_req_write = hold.write;
   assign mem_req_wstrb = hold.wstrb;
   assign mem_req_wdata = hold.wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= OWNER_FETCH;
         hold         <= '0;
         starve_cnt   <= '0;
         drop         <= 1'b0;
         if_rsp_valid <= 1'b0;
         if_rsp_data  <= '0;
         dm_rsp_valid <= 1'b0;
         dm_rsp_rdata <= '0;
         dm_rsp_error <= 1'b0;
      end else begin
         if_rsp_valid <= 1'b0;
         dm_rsp_valid <= 1'b0;
         dm_rsp_error <= 1'b0;
         case (state)
            IDLE: begin
               drop <= 1'b0;
               if (if_hs) begin
                  owner      <= OWNER_FETCH;
                  hold       <= '{addr:  {if_req_addr[MEM_ADDRESS_WIDTH-1:2], 2'b00},
                                  write: 1'b0,
                                  wstrb: 4'b0000,
                                  wdata: '0};
                  starve_cnt <= '0;
                  state      <= ISSUE;
               end else if (dm_hs) begin
                  if (if_req_valid && (starve_cnt != CntMax)) begin
                     starve_cnt <= starve_cnt + CntW'(1);
                  end
                  if (dm_req_write && fmt_misaligned) begin
                     // Accepted but never issued; report back and stay idle.
                     dm_rsp_error <= 1'b1;
                  end else begin
                     owner <= OWNER_DATA;
                     hold  <= '{addr:  {dm_req_addr[MEM_ADDRESS_WIDTH-1:2], 2'b00},
                                write: dm_req_write,
                                wstrb: dm_req_write ? fmt_wstrb : 4'b0000,
                                wdata: dm_req_write ? fmt_wdata : '0};
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (flush_hit) begin
                  drop <= 1'b1;
               end
               if (mem_req_ready) begin
                  state <= hold.write ? IDLE : WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (mem_rsp_valid) begin
                  state <= IDLE;
                  drop  <= 1'b0;
                  if (owner == OWNER_FETCH) begin
                     // A flush in the response cycle also kills the word.
                     if (!drop && !if_flush) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= mem_rsp_rdata;
                     end
                  end else begin
                     dm_rsp_valid <= 1'b1;
                     dm_rsp_rdata <= mem_rsp_rdata;
                  end
               end else if (flush_hit) begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter.
module tb_memory_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [31:0] if_req_addr;
   logic        if_flush;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        dm_req_valid;
   logic        dm_req_ready;
   logic [31:0] dm_req_addr;
   logic        dm_req_write;
   logic [2:0]  dm_req_size;
   logic [31:0] dm_req_wdata;
   logic        dm_rsp_valid;
   logic [31:0] dm_rsp_rdata;
   logic        dm_rsp_error;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_write;
   logic [3:0]  mem_req_wstrb;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   int checks = 0;
   int errors = 0;

   memory_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_valid  (if_req_valid),
      .if_req_ready  (if_req_ready),
      .if_req_addr   (if_req_addr),
      .if_flush      (if_flush),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_data   (if_rsp_data),
      .dm_req_valid  (dm_req_valid),
      .dm_req_ready  (dm_req_ready),
      .dm_req_addr   (dm_req_addr),
      .dm_req_write  (dm_req_write),
      .dm_req_size   (dm_req_size),
      .dm_req_wdata  (dm_req_wdata),
      .dm_rsp_valid  (dm_rsp_valid),
      .dm_rsp_rdata  (dm_rsp_rdata),
      .dm_rsp_error  (dm_rsp_error),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_write (mem_req_write),
      .mem_req_wstrb (mem_req_wstrb),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      chk({tag, ".mem_req_addr"},  mem_req_addr, 32'd0);
      chk({tag, ".mem_req_write"}, {31'd0, mem_req_write}, 32'd0);
      chk({tag, ".mem_req_wstrb"}, {28'd0, mem_req_wstrb}, 32'd0);
      chk({tag, ".mem_req_wdata"}, mem_req_wdata, 32'd0);
      chk({tag, ".if_rsp_valid"},  {31'd0, if_rsp_valid}, 32'd0);
      chk({tag, ".dm_rsp_valid"},  {31'd0, dm_rsp_valid}, 32'd0);
      chk({tag, ".dm_rsp_error"},  {31'd0, dm_rsp_error}, 32'd0);
   endtask

   // Called in an ISSUE cycle: zero-wait ready, response next cycle.
   // Returns just after the edge where the upstream response is visible.
   task automatic serve_read(input logic [31:0] rdata, input logic flush_at_rsp);
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      if_flush      = flush_at_rsp;
      cyc();
      mem_rsp_valid = 1'b0;
      if_flush      = 1'b0;
   endtask

   logic [9:0]  grant_exp;
   logic        got_fetch;
   logic [31:0] rd;

   initial begin
      rst_n         = 1'b0;
      if_req_valid  = 1'b0;
      if_req_addr   = 32'd0;
      if_flush      = 1'b0;
      dm_req_valid  = 1'b0;
      dm_req_addr   = 32'd0;
      dm_req_write  = 1'b0;
      dm_req_size   = 3'd0;
      dm_req_wdata  = 32'd0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'd0;

      // Reset state
      cyc();
      cyc();
      chk_all_zero("reset");
      rst_n = 1'b1;
      cyc();

      // Fetch-only read at 0x100 with zero-wait memory
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0100;
      #1;
      chk("fetch.if_ready", {31'd0, if_req_ready}, 32'd1);
      chk("fetch.dm_ready", {31'd0, dm_req_ready}, 32'd0);
      cyc();
      if_req_valid = 1'b0;
      chk("fetch.n1_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("fetch.n1_addr",  mem_req_addr, 32'h0000_0100);
      chk("fetch.n1_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
      serve_read(32'h0000_0013, 1'b0);
      chk("fetch.n3_valid", {31'd0, if_rsp_valid}, 32'd1);
      chk("fetch.n3_data",  if_rsp_data, 32'h0000_0013);
      chk("fetch.n3_dm",    {31'd0, dm_rsp_valid}, 32'd0);
      cyc();
      chk("fetch.pulse", {31'd0, if_rsp_valid}, 32'd0);

      // SB to 0x203, memory stalls one cycle before ready
      dm_req_valid = 1'b1;
      dm_req_write = 1'b1;
      dm_req_size  = 3'd0;
      dm_req_addr  = 32'h0000_0203;
      dm_req_wdata = 32'h0000_00AB;
      #1;
      chk("sb.dm_ready", {31'd0, dm_req_ready}, 32'd1);
      cyc();
      dm_req_valid = 1'b0;
      dm_req_wdata = 32'h0;
      cyc();
      chk("sb.valid", {31'd0, mem_req_valid}, 32'd1);
      chk("sb.addr",  mem_req_addr, 32'h0000_0200);
      chk("sb.write", {31'd0, mem_req_write}, 32'd1);
      chk("sb.wstrb", {28'd0, mem_req_wstrb}, 32'h8);
      chk("sb.wdata", mem_req_wdata, 32'hABAB_ABAB);
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      #1;
      chk("sb.done_valid", {31'd0, mem_req_valid}, 32'd0);
      cyc();
      chk("sb.no_rsp", {31'd0, dm_rsp_valid}, 32'd0);

      // SH to 0x202: upper half-word lanes
      dm_req_valid = 1'b1;
      dm_req_size  = 3'd1;
      dm_req_addr  = 32'h0000_0202;
      dm_req_wdata = 32'hFFFF_1234;
      cyc();
      dm_req_valid = 1'b0;
      chk("sh.wstrb", {28'd0, mem_req_wstrb}, 32'hC);
      chk("sh.wdata", mem_req_wdata, 32'h1234_1234);
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;

      // SH to 0x201: rejected, error one cycle after accept
      dm_req_valid = 1'b1;
      dm_req_size  = 3'd1;
      dm_req_addr  = 32'h0000_0201;
      #1;
      chk("shmis.dm_ready", {31'd0, dm_req_ready}, 32'd1);
      cyc();
      dm_req_valid = 1'b0;
      chk("shmis.error", {31'd0, dm_rsp_error}, 32'd1);
      chk("shmis.no_req", {31'd0, mem_req_valid}, 32'd0);
      cyc();
      chk("shmis.error_pulse", {31'd0, dm_rsp_error}, 32'd0);
      chk("shmis.no_req2", {31'd0, mem_req_valid}, 32'd0);

      // Illegal size 3 on a write: rejected
      dm_req_valid = 1'b1;
      dm_req_size  = 3'd3;
      dm_req_addr  = 32'h0000_0300;
      cyc();
      dm_req_valid = 1'b0;
      chk("badsize.error", {31'd0, dm_rsp_error}, 32'd1);
      chk("badsize.no_req", {31'd0, mem_req_valid}, 32'd0);
      dm_req_write = 1'b0;
      dm_req_size  = 3'd2;
      cyc();

      // Flush in WAIT_RSP, response three cycles later is dropped
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0300;
      cyc();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      if_flush      = 1'b1;
      cyc();
      if_flush = 1'b0;
      cyc();
      cyc();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'hDEAD_BEEF;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("flush.dropped", {31'd0, if_rsp_valid}, 32'd0);
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0304;
      #1;
      chk("flush.next_grant", {31'd0, if_req_ready}, 32'd1);
      cyc();
      if_req_valid = 1'b0;
      chk("flush.next_addr", mem_req_addr, 32'h0000_0304);
      serve_read(32'h0000_1111, 1'b0);
      chk("flush.cleared", {31'd0, if_rsp_valid}, 32'd1);
      chk("flush.cleared_data", if_rsp_data, 32'h0000_1111);

      // Flush in the same cycle as the memory response
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0308;
      cyc();
      if_req_valid = 1'b0;
      serve_read(32'h0000_2222, 1'b1);
      chk("flush_same.dropped", {31'd0, if_rsp_valid}, 32'd0);

      // Both requesters valid: grant order D,D,D,D,F,D,D,D,D,F
      grant_exp    = 10'b10_0001_0000;
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0400;
      dm_req_valid = 1'b1;
      dm_req_write = 1'b0;
      dm_req_addr  = 32'h0000_0800;
      for (int i = 0; i < 10; i++) begin
         #1;
         got_fetch = if_req_ready;
         chk($sformatf("grant[%0d].fetch", i), {31'd0, got_fetch}, {31'd0, grant_exp[i]});
         chk($sformatf("grant[%0d].any", i), {31'd0, if_req_ready | dm_req_ready}, 32'd1);
         cyc();
         rd = 32'hC000_0000 + i;
         if (i == 9) begin
            if_req_valid = 1'b0;
            dm_req_valid = 1'b0;
         end
         serve_read(rd, 1'b0);
         if (grant_exp[i]) begin
            chk($sformatf("grant[%0d].if_rsp", i), {31'd0, if_rsp_valid}, 32'd1);
            chk($sformatf("grant[%0d].if_data", i), if_rsp_data, rd);
         end else begin
            chk($sformatf("grant[%0d].dm_rsp", i), {31'd0, dm_rsp_valid}, 32'd1);
            chk($sformatf("grant[%0d].dm_data", i), dm_rsp_rdata, rd);
         end
      end
      cyc();

      // Reset during ISSUE with memory stalled
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0500;
      cyc();
      if_req_valid = 1'b0;
      chk("rst.issue_valid", {31'd0, mem_req_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst.async");
      cyc();
      rst_n = 1'b1;
      cyc();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h5555_AAAA;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("rst.stale_if", {31'd0, if_rsp_valid}, 32'd0);
      chk("rst.stale_dm", {31'd0, dm_rsp_valid}, 32'd0);
      chk("rst.stale_req", {31'd0, mem_req_valid}, 32'd0);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
